// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, widths and compare classification
package alu_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 4;
  localparam int CTRL_WIDTH_DEF     = 3;

  localparam logic [CTRL_WIDTH_DEF-1:0] ALU_ID  = 3'd0;
  localparam logic [CTRL_WIDTH_DEF-1:0] ALU_ADD = 3'd1;
  localparam logic [CTRL_WIDTH_DEF-1:0] ALU_SUB = 3'd2;
  localparam logic [CTRL_WIDTH_DEF-1:0] ALU_EQ  = 3'd3;
  localparam logic [CTRL_WIDTH_DEF-1:0] ALU_LE  = 3'd4;
  localparam logic [CTRL_WIDTH_DEF-1:0] ALU_GE  = 3'd5;

  // Compare ops produce a single-bit condition, never a register result
  function automatic logic is_cmp(input logic [CTRL_WIDTH_DEF-1:0] ctrl);
    return (ctrl == ALU_EQ) || (ctrl == ALU_LE) || (ctrl == ALU_GE);
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - general-purpose register file, 2 async reads, 1 sync write, r0 fixed at zero
module reg_file
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; r0 is never written so it stays zero after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports decode r0 explicitly so it reads zero regardless of storage
  assign rdata0 = (raddr0 == '0) ? '0 : mem[raddr0];
  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch, ALU input register and writeback/compare stage
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int CTRL_WIDTH     = CTRL_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [CTRL_WIDTH-1:0]     instr_ctrl,
  input  logic                      instr_in0_is_imm,
  input  logic [DATA_WIDTH-1:0]     instr_imm,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rs0,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
  input  logic                      instr_wr_en,
  output logic [CTRL_WIDTH-1:0]     alu_ctrl,
  output logic [DATA_WIDTH-1:0]     alu_in0,
  output logic [DATA_WIDTH-1:0]     alu_in1,
  input  logic [DATA_WIDTH-1:0]     alu_out,
  output logic                      cmp_valid,
  input  logic                      cmp_ready,
  output logic                      cmp_result
);

  logic                      ex_valid;
  logic                      ex_wr;
  logic                      ex_is_cmp;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;

  logic                      ex_retire;
  logic                      accept;
  logic                      acc_is_cmp;
  logic                      ex_fwd_src;
  logic                      fwd0;
  logic                      fwd1;
  logic                      rf_we;
  logic [DATA_WIDTH-1:0]     rf_rdata0;
  logic [DATA_WIDTH-1:0]     rf_rdata1;
  logic [DATA_WIDTH-1:0]     opnd0;
  logic [DATA_WIDTH-1:0]     opnd1;

  // A compare in EX cannot leave while an older compare result is still unacknowledged
  assign ex_retire   = ex_valid & ~(ex_is_cmp & cmp_valid & ~cmp_ready);
  assign instr_ready = ~ex_valid | ex_retire;
  assign accept      = instr_valid & instr_ready;
  assign acc_is_cmp  = is_cmp(instr_ctrl);

  // EX result is forwardable only when it is a register-writing arithmetic op
  assign ex_fwd_src = ex_valid & ex_wr & ~ex_is_cmp;
  assign fwd0       = ex_fwd_src & (ex_rd == instr_rs0) & (instr_rs0 != '0);
  assign fwd1       = ex_fwd_src & (ex_rd == instr_rs1) & (instr_rs1 != '0);

  assign rf_we = ex_retire & ex_wr & ~ex_is_cmp;

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_reg_file (
    .clk    (clk),
    .rstn   (rstn),
    .raddr0 (instr_rs0),
    .rdata0 (rf_rdata0),
    .raddr1 (instr_rs1),
    .rdata1 (rf_rdata1),
    .we     (rf_we),
    .waddr  (ex_rd),
    .wdata  (alu_out)
  );

  // Operand select: immediate, then forwarded EX result, then register file
  always_comb begin
    opnd0 = rf_rdata0;
    opnd1 = rf_rdata1;
    if (instr_in0_is_imm) opnd0 = instr_imm;
    else if (fwd0)        opnd0 = alu_out;
    if (fwd1)             opnd1 = alu_out;
  end

  // EX register: load on accept, otherwise drain on retire; ALU inputs hold while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_is_cmp <= 1'b0;
      ex_rd     <= '0;
      alu_ctrl  <= '0;
      alu_in0   <= '0;
      alu_in1   <= '0;
    end else if (accept) begin
      ex_valid  <= 1'b1;
      ex_wr     <= instr_wr_en & ~acc_is_cmp;
      ex_is_cmp <= acc_is_cmp;
      ex_rd     <= instr_rd;
      alu_ctrl  <= instr_ctrl;
      alu_in0   <= opnd0;
      alu_in1   <= opnd1;
    end else if (ex_retire) begin
      ex_valid  <= 1'b0;
    end
  end

  // Compare output slot: a retiring compare refills it even in the cycle it is consumed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_valid  <= 1'b0;
      cmp_result <= 1'b0;
    end else if (ex_retire & ex_is_cmp) begin
      cmp_valid  <= 1'b1;
      cmp_result <= alu_out[0];
    end else if (cmp_ready) begin
      cmp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
  import alu_pkg::*;

  typedef struct {
    logic [2:0]  ctrl;
    logic        imm_sel;
    logic [31:0] imm;
    logic [3:0]  rs0;
    logic [3:0]  rs1;
    logic [3:0]  rd;
    logic        wr;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_valid;
  logic        instr_ready;
  instr_t      cur;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [31:0] alu_out;
  logic        cmp_valid;
  logic        cmp_ready;
  logic        cmp_result;
  logic [31:0] junk;

  int total;
  int bad;

  logic [31:0] mreg [16];
  logic        cmp_q [$];
  logic [2:0]  exp_ctrl;
  logic [31:0] exp_in0;
  logic [31:0] exp_in1;

  vec_t tbl [14];

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk              (clk),
    .rstn             (rstn),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_ctrl       (cur.ctrl),
    .instr_in0_is_imm (cur.imm_sel),
    .instr_imm        (cur.imm),
    .instr_rs0        (cur.rs0),
    .instr_rs1        (cur.rs1),
    .instr_rd         (cur.rd),
    .instr_wr_en      (cur.wr),
    .alu_ctrl         (alu_ctrl),
    .alu_in0          (alu_in0),
    .alu_in1          (alu_in1),
    .alu_out          (alu_out),
    .cmp_valid        (cmp_valid),
    .cmp_ready        (cmp_ready),
    .cmp_result       (cmp_result)
  );

  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return {31'd0, a == b};
      3'd4:    return {31'd0, a <= b};
      3'd5:    return {31'd0, a >= b};
      default: return 32'd0;
    endcase
  endfunction

  // Combinational ALU; compare ops carry garbage in the upper bits
  always_comb begin
    alu_out = alu_ref(alu_ctrl, alu_in0, alu_in1);
    if (alu_ctrl >= 3'd3 && alu_ctrl <= 3'd5) alu_out = {junk[31:1], alu_out[0]};
  end

  function automatic instr_t mk(input logic [2:0] c, input logic s, input logic [31:0] im,
                                input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                                input logic w);
    instr_t i;
    i.ctrl = c; i.imm_sel = s; i.imm = im; i.rs0 = a; i.rs1 = b; i.rd = d; i.wr = w;
    return i;
  endfunction

  function automatic vec_t mv(input instr_t i, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v.ins = i; v.e0 = a; v.e1 = b;
    return v;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i.ctrl    = 3'($urandom_range(0, 5));
    i.imm_sel = 1'($urandom_range(0, 1));
    i.imm     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
    i.rs0     = 4'($urandom_range(0, 7));
    i.rs1     = 4'($urandom_range(0, 7));
    i.rd      = 4'($urandom_range(0, 7));
    i.wr      = ($urandom_range(0, 3) != 0);
    return i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  // Architectural model: each accepted instruction executes completely, in order
  task automatic model_accept(input instr_t i);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    a = i.imm_sel ? i.imm : mreg[i.rs0];
    b = mreg[i.rs1];
    r = alu_ref(i.ctrl, a, b);
    exp_ctrl = i.ctrl;
    exp_in0  = a;
    exp_in1  = b;
    if (i.ctrl >= 3'd3) cmp_q.push_back(r[0]);
    else if (i.wr && i.rd != 4'd0) mreg[i.rd] = r;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
    cmp_q.delete();
  endtask

  // One clock: observe handshakes, advance model, then check ALU inputs in the following cycle
  task automatic clock_edge(output logic acc);
    logic hs;
    #1;
    acc = instr_valid & instr_ready;
    hs  = cmp_valid & cmp_ready;
    if (hs) begin
      if (cmp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL cmp_unexpected got=%0d want=none", cmp_result);
      end else begin
        chk("cmp_result", {31'd0, cmp_result}, {31'd0, cmp_q.pop_front()});
      end
    end
    if (acc) model_accept(cur);
    @(posedge clk);
    @(negedge clk);
    junk = $urandom;
    if (acc) begin
      chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, exp_ctrl});
      chk("alu_in0", alu_in0, exp_in0);
      chk("alu_in1", alu_in1, exp_in1);
    end
  endtask

  task automatic issue(input instr_t ins, input logic cr, input logic rnd_cr);
    logic done;
    logic a;
    done = 1'b0;
    cur = ins;
    instr_valid = 1'b1;
    cmp_ready = cr;
    for (int n = 0; n < 64 && !done; n++) begin
      if (rnd_cr) cmp_ready = ($urandom_range(0, 3) != 0);
      clock_edge(a);
      done = a;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout got=not_accepted want=accepted");
    end
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic cr);
    logic a;
    instr_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      cmp_ready = cr;
      clock_edge(a);
    end
  endtask

  initial begin
    logic a;
    total = 0;
    bad = 0;
    junk = 32'd0;
    rstn = 1'b0;
    instr_valid = 1'b0;
    cmp_ready = 1'b0;
    cur = mk(3'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    model_reset();

    tbl[0]  = mv(mk(ALU_ID,  1, 32'd5,        4'd0, 4'd0, 4'd3, 1), 32'd5,        32'd0);
    tbl[1]  = mv(mk(ALU_ADD, 0, 32'd0,        4'd3, 4'd3, 4'd4, 1), 32'd5,        32'd5);
    tbl[2]  = mv(mk(ALU_ADD, 0, 32'd0,        4'd4, 4'd0, 4'd7, 0), 32'd10,       32'd0);
    tbl[3]  = mv(mk(ALU_ID,  1, 32'hFFFFFFFF, 4'd0, 4'd0, 4'd1, 1), 32'hFFFFFFFF, 32'd0);
    tbl[4]  = mv(mk(ALU_ID,  1, 32'd1,        4'd0, 4'd0, 4'd2, 1), 32'd1,        32'd0);
    tbl[5]  = mv(mk(ALU_ADD, 0, 32'd0,        4'd1, 4'd2, 4'd5, 1), 32'hFFFFFFFF, 32'd1);
    tbl[6]  = mv(mk(ALU_ADD, 0, 32'd0,        4'd5, 4'd0, 4'd7, 0), 32'd0,        32'd0);
    tbl[7]  = mv(mk(ALU_SUB, 0, 32'd0,        4'd2, 4'd1, 4'd5, 1), 32'd1,        32'hFFFFFFFF);
    tbl[8]  = mv(mk(ALU_ID,  0, 32'd0,        4'd5, 4'd5, 4'd7, 0), 32'd2,        32'd2);
    tbl[9]  = mv(mk(ALU_ID,  1, 32'd9,        4'd0, 4'd0, 4'd0, 1), 32'd9,        32'd0);
    tbl[10] = mv(mk(ALU_ADD, 0, 32'd0,        4'd0, 4'd0, 4'd7, 0), 32'd0,        32'd0);
    tbl[11] = mv(mk(ALU_ID,  1, 32'h1234,     4'd0, 4'd0, 4'd6, 1), 32'h1234,     32'd0);
    tbl[12] = mv(mk(ALU_EQ,  0, 32'd0,        4'd6, 4'd6, 4'd6, 1), 32'h1234,     32'h1234);
    tbl[13] = mv(mk(ALU_ID,  0, 32'd0,        4'd6, 4'd6, 4'd7, 0), 32'h1234,     32'h1234);

    repeat (2) @(negedge clk);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("rst_alu_in0", alu_in0, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_cmp_valid", {31'd0, cmp_valid}, 32'd0);
    chk("rst_cmp_result", {31'd0, cmp_result}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      issue(tbl[k].ins, 1'b1, 1'b0);
      chk($sformatf("vec%0d_in0", k), alu_in0, tbl[k].e0);
      chk($sformatf("vec%0d_in1", k), alu_in1, tbl[k].e1);
    end
    idle(2, 1'b1);

    issue(mk(ALU_ID, 1, 32'd3, 4'd0, 4'd0, 4'd1, 1), 1'b1, 1'b0);
    issue(mk(ALU_ID, 1, 32'd7, 4'd0, 4'd0, 4'd2, 1), 1'b1, 1'b0);
    issue(mk(ALU_LE, 0, 32'd0, 4'd1, 4'd2, 4'd9, 0), 1'b0, 1'b0);
    chk("le_cmp_valid_latency", {31'd0, cmp_valid}, 32'd0);
    issue(mk(ALU_EQ, 0, 32'd0, 4'd1, 4'd2, 4'd9, 0), 1'b0, 1'b0);
    chk("le_cmp_valid", {31'd0, cmp_valid}, 32'd1);
    chk("le_cmp_result", {31'd0, cmp_result}, 32'd1);
    cur = mk(ALU_ID, 1, 32'hAA, 4'd0, 4'd0, 4'd8, 1);
    instr_valid = 1'b1;
    cmp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_instr_ready", {31'd0, instr_ready}, 32'd0);
      chk("stall_cmp_valid", {31'd0, cmp_valid}, 32'd1);
      chk("stall_cmp_result", {31'd0, cmp_result}, 32'd1);
      chk("stall_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, ALU_EQ});
      chk("stall_alu_in0", alu_in0, 32'd3);
      chk("stall_alu_in1", alu_in1, 32'd7);
      clock_edge(a);
    end
    cmp_ready = 1'b1;
    #1;
    chk("release_instr_ready", {31'd0, instr_ready}, 32'd1);
    clock_edge(a);
    chk("release_accept", {31'd0, a}, 32'd1);
    instr_valid = 1'b0;
    #1;
    chk("eq_cmp_valid_held", {31'd0, cmp_valid}, 32'd1);
    chk("eq_cmp_result", {31'd0, cmp_result}, 32'd0);
    idle(2, 1'b1);

    issue(mk(ALU_EQ, 0, 32'd0, 4'd1, 4'd1, 4'd0, 0), 1'b0, 1'b0);
    idle(1, 1'b0);
    issue(mk(ALU_ID, 1, 32'd77, 4'd0, 4'd0, 4'd3, 1), 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_cmp_valid", {31'd0, cmp_valid}, 32'd0);
    chk("midrst_cmp_result", {31'd0, cmp_result}, 32'd0);
    chk("midrst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("midrst_alu_in0", alu_in0, 32'd0);
    chk("midrst_alu_in1", alu_in1, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    issue(mk(ALU_ADD, 0, 32'd0, 4'd3, 4'd3, 4'd7, 0), 1'b1, 1'b0);
    chk("post_rst_r3_in0", alu_in0, 32'd0);
    chk("post_rst_r3_in1", alu_in1, 32'd0);

    for (int k = 0; k < 400; k++) begin
      issue(rnd_instr(), 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
    end
    for (int r = 1; r < 8; r++) begin
      issue(mk(ALU_ID, 0, 32'd0, 4'(r), 4'(r), 4'd0, 0), 1'b1, 1'b0);
    end
    idle(6, 1'b1);
    chk("cmp_drain", 32'(cmp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
